// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file with busy scoreboard.
package regfile_2r1w_sb_pkg;

    // Default geometry: 32 registers of 32 bits.
    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Address of the optional hardwired-zero register.
    localparam int unsigned REG_ZERO = 0;

    // Number of registers addressed by an ADDR_W-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sb_word.sv
// One register word: falling-edge clocked, async active-low clear, write enable.
module reg_word_negclk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    // Capture d_i on the falling edge when enabled; clear immediately on reset.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else if (en_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a
// per-register busy scoreboard (set by decode, cleared by writeback).
module regfile_2r1w_sb
    import regfile_2r1w_sb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              busy_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              busy_b,
    input  logic              bset,
    input  logic [ADDR_W-1:0] bset_addr,
    output logic              any_busy
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DEPTH*WIDTH-1:0] regs_flat;
    logic [DEPTH-1:0]       busy_q;
    logic [DEPTH-1:0]       busy_d;
    logic                   wr_ok;
    logic                   bset_ok;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [WIDTH-1:0]  rd_data [2];
    logic              rd_busy [2];

    // Storage array: the zero register, when enabled, is a constant rather than a flop.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        if (ZERO_REG && (gi == REG_ZERO)) begin : g_zero
            assign regs_flat[gi*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            reg_word_negclk #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk_i  (clk),
                .rst_ni (reset),
                .en_i   (we && (waddr == ADDR_W'(gi))),
                .d_i    (wdata),
                .q_o    (regs_flat[gi*WIDTH +: WIDTH])
            );
        end
    end

    // Writes and busy-sets aimed at the zero register are dropped.
    always_comb begin
        wr_ok   = we;
        bset_ok = bset;
        if (ZERO_REG) begin
            if (waddr == ADDR_W'(REG_ZERO)) begin
                wr_ok = 1'b0;
            end
            if (bset_addr == ADDR_W'(REG_ZERO)) begin
                bset_ok = 1'b0;
            end
        end
    end

    // Scoreboard next state: writeback clears, then a new issue sets (set wins on a tie).
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[waddr] = 1'b0;
        end
        if (bset_ok) begin
            busy_d[bset_addr] = 1'b1;
        end
    end

    // Scoreboard register, updated on the falling edge like the data words.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_addr[0] = raddr_a;
    assign rd_addr[1] = raddr_b;

    // Two identical read ports; the zero register overrides bypass, bypass overrides storage.
    for (genvar gp = 0; gp < 2; gp++) begin : g_rport
        // Combinational read with optional same-cycle forwarding of the write port.
        always_comb begin
            rd_data[gp] = regs_flat[WIDTH*32'(rd_addr[gp]) +: WIDTH];
            rd_busy[gp] = busy_q[rd_addr[gp]];
            if (ZERO_REG && (rd_addr[gp] == ADDR_W'(REG_ZERO))) begin
                rd_data[gp] = '0;
                rd_busy[gp] = 1'b0;
            end else if (BYPASS && we && (waddr == rd_addr[gp])) begin
                rd_data[gp] = wdata;
                rd_busy[gp] = bset && (bset_addr == rd_addr[gp]);
            end
        end
    end

    assign rdata_a  = rd_data[0];
    assign busy_a   = rd_busy[0];
    assign rdata_b  = rd_data[1];
    assign busy_b   = rd_busy[1];
    assign any_busy = |busy_q;

endmodule
